sb_interconnect: RTL

Parametrised system-bus interconnect between the LSU memory port and the peripheral controllers. It replaces fixed top-level address decoding and the compile-time selection of a single interrupt source. The block decodes the slave index from an address bit-field and runs one transaction at a time through a request/wait/response state machine with per-slave ready handling. It returns a bus error for unmapped or timed-out accesses and arbitrates several peripheral interrupt lines onto the single core interrupt request.

---
 rtl/sb_interconnect_pkg.sv | 21 ++
 rtl/sb_irq_arbiter.sv | 60 ++++++
 rtl/sb_interconnect.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sb_interconnect_pkg.sv
// Shared types for the system-bus interconnect.
// Bus and IRQ FSM state enums plus the select-field width helper.
package sb_interconnect_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } bus_state_t;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_BUSY,
        IRQ_RET
    } irq_state_t;

    function automatic int sel_w(input int msb, input int lsb);
        return msb - lsb + 1;
    endfunction

endpackage

// File: rtl/sb_irq_arbiter.sv
// Fixed-priority interrupt arbiter: latches the lowest pending line,
// holds core_irq_o until mret, then pulses irq_ret_o for that line.
// Ports: clk_i, resetn_i, irq_i, core_irq_ret_i -> core_irq_o, irq_ret_o.
module sb_irq_arbiter
    import sb_interconnect_pkg::*;
#(
    parameter int N_IRQ = 3
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             core_irq_ret_i,
    output logic             core_irq_o,
    output logic [N_IRQ-1:0] irq_ret_o
);

    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_t      state_q;
    irq_state_t      state_n;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] pick;

    // Scan downwards so the lowest set index wins.
    always_comb begin
        pick = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq_i[i]) pick = ID_W'(i);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IRQ_IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_n;
            if (state_q == IRQ_IDLE && |irq_i) id_q <= pick;
        end
    end

    always_comb begin
        state_n    = state_q;
        core_irq_o = 1'b0;
        irq_ret_o  = '0;
        unique case (state_q)
            IRQ_IDLE: if (|irq_i) state_n = IRQ_BUSY;
            IRQ_BUSY: begin
                core_irq_o = 1'b1;
                if (core_irq_ret_i) state_n = IRQ_RET;
            end
            IRQ_RET: begin
                irq_ret_o = N_IRQ'(1) << id_q;
                state_n   = IRQ_IDLE;
            end
            default: state_n = IRQ_IDLE;
        endcase
    end

endmodule

// File: rtl/sb_interconnect.sv
// System-bus interconnect: address-field slave decode, single outstanding
// transaction (IDLE/WAIT/RESP), timeout, sticky error log, IRQ arbiter.
// Ports: master m_*, broadcast slave s_*, err_*, irq_*/core_irq_*.
module sb_interconnect
    import sb_interconnect_pkg::*;
#(
    parameter int                  N_SLAVES   = 8,
    parameter int                  SEL_MSB    = 31,
    parameter int                  SEL_LSB    = 24,
    parameter logic [N_SLAVES-1:0] READY_MASK = N_SLAVES'(1),
    parameter int                  TIMEOUT    = 64,
    parameter int                  N_IRQ      = 3
) (
    input  logic                   clk_i,
    input  logic                   resetn_i,
    input  logic                   m_req_i,
    input  logic                   m_we_i,
    input  logic [3:0]             m_be_i,
    input  logic [31:0]            m_addr_i,
    input  logic [31:0]            m_wd_i,
    output logic [31:0]            m_rd_o,
    output logic                   m_ready_o,
    output logic                   m_err_o,
    output logic [N_SLAVES-1:0]    s_req_o,
    output logic                   s_we_o,
    output logic [3:0]             s_be_o,
    output logic [31:0]            s_addr_o,
    output logic [31:0]            s_wd_o,
    input  logic [N_SLAVES*32-1:0] s_rd_i,
    input  logic [N_SLAVES-1:0]    s_ready_i,
    output logic                   err_valid_o,
    output logic [31:0]            err_addr_o,
    input  logic                   err_clr_i,
    input  logic [N_IRQ-1:0]       irq_i,
    output logic [N_IRQ-1:0]       irq_ret_o,
    output logic                   core_irq_o,
    input  logic                   core_irq_ret_i
);

    localparam int          SEL_W    = sel_w(SEL_MSB, SEL_LSB);
    localparam int          IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [31:0] LOW_MASK = ~(32'hFFFF_FFFF << SEL_LSB);

    bus_state_t       state_q;
    bus_state_t       state_n;
    logic [IDX_W-1:0] idx_q;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      addr_q;
    logic [31:0]      wd_q;
    logic [31:0]      rd_q;
    logic             err_q;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_n;
    logic             err_valid_q;
    logic [31:0]      err_addr_q;

    logic [SEL_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic             take;
    logic             done;
    logic             fail;
    logic             drive;
    logic [31:0]      fail_addr;
    logic [31:0]      rd_arr [N_SLAVES];

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_rd
        assign rd_arr[i] = s_rd_i[32*i +: 32];
    end

    assign sel = m_addr_i[SEL_MSB:SEL_LSB];
    assign idx = sel[IDX_W-1:0];
    // Extra bit keeps the compare correct when N_SLAVES fills the field.
    assign hit = ({1'b0, sel} < (SEL_W+1)'(N_SLAVES));

    assign fail_addr = (state_q == IDLE) ? m_addr_i : addr_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = '0;
        take    = 1'b0;
        done    = 1'b0;
        fail    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m_req_i) begin
                    state_n = RESP;
                    take    = hit;
                    fail    = !hit;
                    if (hit) state_n = WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt_q + 8'd1;
                // Ready is checked first so it beats a same-cycle timeout.
                if (!READY_MASK[idx_q] || s_ready_i[idx_q]) begin
                    state_n = RESP;
                    done    = 1'b1;
                end else if (cnt_n == 8'(TIMEOUT)) begin
                    state_n = RESP;
                    fail    = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wd_q        <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            if (take) begin
                idx_q  <= idx;
                we_q   <= m_we_i;
                be_q   <= m_be_i;
                addr_q <= m_addr_i;
                wd_q   <= m_wd_i;
            end
            if (done) rd_q <= rd_arr[idx_q];
            if (take || fail) err_q <= fail;
            if (err_clr_i) begin
                err_valid_q <= 1'b0;
                err_addr_q  <= '0;
            end else if (fail && !err_valid_q) begin
                err_valid_q <= 1'b1;
                err_addr_q  <= fail_addr;
            end
        end
    end

    // Gating with resetn_i keeps s_req_o low while reset is held
    // even if the master keeps requesting.
    assign drive   = resetn_i && m_req_i && hit && (state_q == IDLE);
    assign s_req_o = drive ? (N_SLAVES'(1) << idx) : '0;

    always_comb begin
        s_we_o   = 1'b0;
        s_be_o   = '0;
        s_addr_o = '0;
        s_wd_o   = '0;
        if (drive) begin
            s_we_o   = m_we_i;
            s_be_o   = m_be_i;
            s_addr_o = m_addr_i & LOW_MASK;
            s_wd_o   = m_wd_i;
        end else if (state_q == WAIT) begin
            s_we_o   = we_q;
            s_be_o   = be_q;
            s_addr_o = addr_q & LOW_MASK;
            s_wd_o   = wd_q;
        end
    end

    assign m_ready_o   = (state_q == RESP);
    assign m_err_o     = m_ready_o && err_q;
    assign m_rd_o      = (m_ready_o && !err_q) ? rd_q : '0;
    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;

    sb_irq_arbiter #(
        .N_IRQ(N_IRQ)
    ) u_irq (
        .clk_i         (clk_i),
        .resetn_i      (resetn_i),
        .irq_i         (irq_i),
        .core_irq_ret_i(core_irq_ret_i),
        .core_irq_o    (core_irq_o),
        .irq_ret_o     (irq_ret_o)
    );

endmodule
